// File: rtl/execute_y_pkg.sv
// Shared definitions for the Y multiply unit: op encoding, unit select code
// and the record carried by every pipeline stage.
package execute_y_pkg;

    typedef enum logic [1:0] {
        Y_OP_MUL    = 2'b00,
        Y_OP_MULH   = 2'b01,
        Y_OP_MULHU  = 2'b10,
        Y_OP_MULHSU = 2'b11
    } y_op_e;

    localparam logic [1:0] Y_FU_ID = 2'd3;

    // Stage records are sized for the widest supported configuration
    // (DATA_W up to 64, REG_W below 16); narrower builds leave the upper
    // payload/regdest bits at zero and synthesis trims them.
    localparam int DATA_MAX_W    = 64;
    localparam int REG_MAX_W     = 16;
    localparam int PAYLOAD_MAX_W = 4 * DATA_MAX_W + 8;

    // valid is the first field, so it lands on the MSB of the packed record.
    typedef struct packed {
        logic                     valid;
        y_op_e                    op;
        logic [REG_MAX_W-1:0]     regdest;
        logic [PAYLOAD_MAX_W-1:0] payload;
    } y_stage_t;

    function automatic logic is_high_half(y_op_e op);
        return op != Y_OP_MUL;
    endfunction

endpackage

// File: rtl/execute_y_mul_pipe_if.sv
// Issue/writeback connection of the Y multiply unit.
// master: issue + writeback side; slave: the multiply pipeline.
interface execute_y_mul_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              is_y_valid;
    logic [1:0]        is_y_functionalunit;
    logic [1:0]        is_y_op;
    logic [DATA_W-1:0] is_y_rega;
    logic [DATA_W-1:0] is_y_regb;
    logic [REG_W-1:0]  is_y_regdest;
    logic              is_y_ready;
    logic              wb_y_ready;
    logic              y_wb_valid;
    logic [REG_W-1:0]  y_wb_regdest;
    logic              y_wb_writereg;
    logic [DATA_W-1:0] y_wb_wbvalue;
    logic              y_busy;

    modport master (
        output is_y_valid, is_y_functionalunit, is_y_op, is_y_rega, is_y_regb,
               is_y_regdest, wb_y_ready,
        input  is_y_ready, y_wb_valid, y_wb_regdest, y_wb_writereg,
               y_wb_wbvalue, y_busy
    );

    modport slave (
        input  is_y_valid, is_y_functionalunit, is_y_op, is_y_rega, is_y_regb,
               is_y_regdest, wb_y_ready,
        output is_y_ready, y_wb_valid, y_wb_regdest, y_wb_writereg,
               y_wb_wbvalue, y_busy
    );
endinterface

// File: rtl/execute_y_stage_reg.sv
// One pipeline stage register. Bit W-1 is the stage valid flag.
// Holds while adv is low; flush drops only the valid flag and freezes data.
module execute_y_stage_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         adv,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // stage capture with stall hold and valid-only flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q[W-1] <= 1'b0;
        end else if (adv) begin
            q <= d;
        end
    end

endmodule

// File: rtl/execute_y_mul_pipe.sv
// Y functional unit: pipelined DATA_W x DATA_W multiplier with MUL/MULH/
// MULHU/MULHSU, valid/ready issue handshake and writeback backpressure.
// Stage 0 extends operands, stage 1 forms four half-width partial products,
// stage 2 sums and selects the result half (folded into stage 1 when
// STAGES == 2); later stages only delay. The stall is global.
// Optional build macro EXECUTE_Y_FLUSH_EN adds the y_flush input, which
// clears all stage valids on the next edge.
module execute_y_mul_pipe #(
    parameter int         DATA_W  = 32,
    parameter int         STAGES  = 4,
    parameter int         REG_W   = 5,
    parameter logic [1:0] Y_FU_ID = execute_y_pkg::Y_FU_ID
) (
    input logic clock,
    input logic reset,
`ifdef EXECUTE_Y_FLUSH_EN
    input logic y_flush,
`endif
    execute_y_mul_pipe_if.slave bus
);
    import execute_y_pkg::*;

    localparam int H  = DATA_W / 2;
    localparam int XW = DATA_W + 1;   // extended operand
    localparam int PW = DATA_W + 2;   // one partial product
    localparam int RW = 2 * DATA_W;   // full product
    localparam int SW = $bits(y_stage_t);

    logic              flush;
    logic              adv;
    logic              acc;
    logic              busy;
    logic              sign_a;
    logic              sign_b;
    logic [XW-1:0]     ext_a;
    logic [XW-1:0]     ext_b;
    y_stage_t          stage0_d;
    y_stage_t          stage_q [STAGES];
    y_stage_t          last;
    logic              unused_last;

`ifdef EXECUTE_Y_FLUSH_EN
    assign flush = y_flush;
`else
    assign flush = 1'b0;
`endif

    // Each extended operand splits into a signed high half (H+1 bits) and an
    // unsigned low half; the low half gets a zero MSB so all four products
    // are plain signed (H+1)x(H+1) multiplies.
    function automatic logic [4*PW-1:0] partials(logic [2*XW-1:0] ops);
        logic [XW-1:0]        ax;
        logic [XW-1:0]        bx;
        logic signed [H:0]    ah;
        logic signed [H:0]    al;
        logic signed [H:0]    bh;
        logic signed [H:0]    bl;
        logic signed [PW-1:0] hh;
        logic signed [PW-1:0] hl;
        logic signed [PW-1:0] lh;
        logic signed [PW-1:0] ll;
        {ax, bx} = ops;
        ah = ax[DATA_W:H];
        al = {1'b0, ax[H-1:0]};
        bh = bx[DATA_W:H];
        bl = {1'b0, bx[H-1:0]};
        hh = PW'(ah) * PW'(bh);
        hl = PW'(ah) * PW'(bl);
        lh = PW'(al) * PW'(bh);
        ll = PW'(al) * PW'(bl);
        return {hh, hl, lh, ll};
    endfunction

    function automatic logic [RW-1:0] sum_partials(logic [4*PW-1:0] pp);
        logic signed [PW-1:0] hh;
        logic signed [PW-1:0] hl;
        logic signed [PW-1:0] lh;
        logic signed [PW-1:0] ll;
        {hh, hl, lh, ll} = pp;
        return (RW'(hh) << DATA_W) + (RW'(hl) << H) + (RW'(lh) << H) + RW'(ll);
    endfunction

    function automatic logic [DATA_W-1:0] select_result(y_op_e op, logic [RW-1:0] product);
        return is_high_half(op) ? product[RW-1:DATA_W] : product[DATA_W-1:0];
    endfunction

    assign last           = stage_q[STAGES-1];
    assign adv            = ~last.valid | bus.wb_y_ready;
    assign bus.is_y_ready = reset & adv & ~flush;
    assign acc            = bus.is_y_valid & (bus.is_y_functionalunit == Y_FU_ID) & bus.is_y_ready;

    // issue capture: operand extension per op signedness
    always_comb begin
        sign_a = 1'b1;
        sign_b = 1'b1;
        case (y_op_e'(bus.is_y_op))
            Y_OP_MULHU: begin
                sign_a = 1'b0;
                sign_b = 1'b0;
            end
            Y_OP_MULHSU: sign_b = 1'b0;
            default: ;
        endcase
        ext_a = {sign_a & bus.is_y_rega[DATA_W-1], bus.is_y_rega};
        ext_b = {sign_b & bus.is_y_regb[DATA_W-1], bus.is_y_regb};
        stage0_d         = '0;
        stage0_d.valid   = acc;
        stage0_d.op      = y_op_e'(bus.is_y_op);
        stage0_d.regdest = REG_MAX_W'(bus.is_y_regdest);
        stage0_d.payload = PAYLOAD_MAX_W'({ext_a, ext_b});
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        y_stage_t d;

        if (k == 0) begin : g_issue
            assign d = stage0_d;
        end else if (k == 1 && STAGES == 2) begin : g_fold
            // short pipe: partial products, sum and half select in one stage
            always_comb begin
                d = stage_q[0];
                d.payload = PAYLOAD_MAX_W'(select_result(stage_q[0].op,
                    sum_partials(partials(stage_q[0].payload[2*XW-1:0]))));
            end
        end else if (k == 1) begin : g_partial
            // partial products from the extended operands
            always_comb begin
                d = stage_q[0];
                d.payload = PAYLOAD_MAX_W'(partials(stage_q[0].payload[2*XW-1:0]));
            end
        end else if (k == 2) begin : g_sum
            // product sum and high/low half select
            always_comb begin
                d = stage_q[1];
                d.payload = PAYLOAD_MAX_W'(select_result(stage_q[1].op,
                    sum_partials(stage_q[1].payload[4*PW-1:0])));
            end
        end else begin : g_delay
            assign d = stage_q[k-1];
        end

        execute_y_stage_reg #(.W(SW)) u_reg (
            .clock (clock),
            .reset (reset),
            .adv   (adv),
            .flush (flush),
            .d     (d),
            .q     (stage_q[k])
        );
    end

    // busy whenever any stage holds a valid op
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            busy = busy | stage_q[i].valid;
        end
    end

    assign bus.y_wb_valid    = last.valid;
    assign bus.y_wb_regdest  = last.regdest[REG_W-1:0];
    assign bus.y_wb_writereg = last.valid & (last.regdest != '0);
    assign bus.y_wb_wbvalue  = last.payload[DATA_W-1:0];
    assign bus.y_busy        = busy;

    assign unused_last = ^{last.payload[PAYLOAD_MAX_W-1:DATA_W],
                           last.regdest[REG_MAX_W-1:REG_W], last.op};

endmodule
